// File: rtl/alu_word_sequencer.sv
// Word-wide ADD/SUB/AND/OR sequencer driving a shared 8-bit ALU one byte per cycle,
// LSB first, with carry/borrow chained between bytes through a local register.
module alu_word_sequencer #(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BYTES-1:0]   in_left,
  input  logic [8*BYTES-1:0]   in_right,
  input  logic [1:0]           in_opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   out_result,
  output logic                 out_carry,
  output logic                 out_zero,
  output logic [7:0]           alu_left,
  output logic [7:0]           alu_right,
  output logic [1:0]           alu_opcode,
  output logic                 alu_status_in,
  input  logic [7:0]           alu_result,
  input  logic                 alu_status_out
);

  localparam int W  = 8 * BYTES;
  localparam int IW = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    left_q, left_d;
  logic [W-1:0]    right_q, right_d;
  logic [1:0]      opcode_q, opcode_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            zero_q, zero_d;

  logic            lastByte;
  logic            logicOp;

  assign lastByte = (idx_q == IW'(BYTES - 1));
  assign logicOp  = opcode_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (lastByte) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The ALU sees operand bytes only while running; it is held at zero otherwise.
  always_comb begin
    in_ready      = (state_q == IDLE);
    out_valid     = (state_q == DONE);
    alu_left      = 8'd0;
    alu_right     = 8'd0;
    alu_opcode    = 2'd0;
    alu_status_in = 1'b0;
    if (state_q == RUN) begin
      alu_left      = left_q[idx_q*8 +: 8];
      alu_right     = right_q[idx_q*8 +: 8];
      alu_opcode    = opcode_q;
      alu_status_in = (idx_q != '0) && !logicOp && carry_q;
    end
  end

  always_comb begin
    left_d   = left_q;
    right_d  = right_q;
    opcode_d = opcode_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          left_d   = in_left;
          right_d  = in_right;
          opcode_d = in_opcode;
          idx_d    = '0;
          carry_d  = 1'b0;
        end
      end
      RUN: begin
        result_d[idx_q*8 +: 8] = alu_result;
        carry_d                = logicOp ? 1'b0 : alu_status_out;
        idx_d                  = idx_q + IW'(1);
        // Zero flag is taken from the fully assembled word, including the final byte.
        if (lastByte) begin
          zero_d = (result_d == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left_q   <= '0;
      right_q  <= '0;
      opcode_q <= 2'd0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      left_q   <= left_d;
      right_q  <= right_d;
      opcode_q <= opcode_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer (BYTES=4) with a behavioural 8-bit ALU beside it.
module tb_alu_word_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] inLeft;
  logic [31:0] inRight;
  logic [1:0]  inOpcode;
  logic        outValid;
  logic        outReady;
  logic [31:0] outResult;
  logic        outCarry;
  logic        outZero;
  logic [7:0]  aluLeft;
  logic [7:0]  aluRight;
  logic [1:0]  aluOpcode;
  logic        aluStatusIn;
  logic [7:0]  aluResult;
  logic        aluStatusOut;
  logic [8:0]  aluWide;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  alu_word_sequencer #(.BYTES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .in_left       (inLeft),
    .in_right      (inRight),
    .in_opcode     (inOpcode),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_result    (outResult),
    .out_carry     (outCarry),
    .out_zero      (outZero),
    .alu_left      (aluLeft),
    .alu_right     (aluRight),
    .alu_opcode    (aluOpcode),
    .alu_status_in (aluStatusIn),
    .alu_result    (aluResult),
    .alu_status_out(aluStatusOut)
  );

  always #5 clk = ~clk;

  // Behavioural alu8: bit 8 of the 9-bit result is carry for ADD and borrow for SUB.
  always_comb begin
    aluWide = 9'd0;
    case (aluOpcode)
      2'd0:    aluWide = {1'b0, aluLeft} + {1'b0, aluRight} + {8'd0, aluStatusIn};
      2'd1:    aluWide = {1'b0, aluLeft} - {1'b0, aluRight} - {8'd0, aluStatusIn};
      2'd2:    aluWide = {1'b0, aluLeft & aluRight};
      default: aluWide = {1'b0, aluLeft | aluRight};
    endcase
  end
  assign aluResult    = aluWide[7:0];
  assign aluStatusOut = aluWide[8];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expected carry/borrow entering byte k, derived from whole-word arithmetic on the low k bytes.
  function automatic logic expStatus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input int k);
    logic [63:0] mask;
    logic [63:0] la;
    logic [63:0] lb;
    if (k == 0 || op[1]) return 1'b0;
    mask = (64'd1 << (8 * k)) - 64'd1;
    la   = {32'd0, a} & mask;
    lb   = {32'd0, b} & mask;
    if (op == OP_ADD) return ((la + lb) >> (8 * k)) != 64'd0;
    return la < lb;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int waitCycles = 0;
    while (!inReady && waitCycles < 20) begin
      stepCycle();
      waitCycles++;
    end
    checkOutput("inReadyBeforeAccept", 32'(inReady), 32'd1);
    inValid  = 1'b1;
    inLeft   = a;
    inRight  = b;
    inOpcode = op;
    stepCycle();
    inValid = 1'b0;
  endtask

  task automatic checkRun(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("runOutValid[%0d]", k), 32'(outValid), 32'd0);
      checkOutput($sformatf("runInReady[%0d]", k), 32'(inReady), 32'd0);
      checkOutput($sformatf("aluLeft[%0d]", k), 32'(aluLeft), 32'(a[k*8 +: 8]));
      checkOutput($sformatf("aluRight[%0d]", k), 32'(aluRight), 32'(b[k*8 +: 8]));
      checkOutput($sformatf("aluOpcode[%0d]", k), 32'(aluOpcode), 32'(op));
      checkOutput($sformatf("aluStatusIn[%0d]", k), 32'(aluStatusIn), 32'(expStatus(op, a, b, k)));
      stepCycle();
    end
  endtask

  task automatic checkResult(input string tag, input logic [31:0] expR, input logic expC, input logic expZ);
    checkOutput({tag, ".outValid"}, 32'(outValid), 32'd1);
    checkOutput({tag, ".outResult"}, outResult, expR);
    checkOutput({tag, ".outCarry"}, 32'(outCarry), 32'(expC));
    checkOutput({tag, ".outZero"}, 32'(outZero), 32'(expZ));
  endtask

  task automatic consume(input string tag, input logic [31:0] expR);
    outReady = 1'b1;
    stepCycle();
    checkOutput({tag, ".idleOutValid"}, 32'(outValid), 32'd0);
    checkOutput({tag, ".idleInReady"}, 32'(inReady), 32'd1);
    checkOutput({tag, ".idleHold"}, outResult, expR);
  endtask

  initial begin
    int validSeen;
    reset    = 1'b1;
    inValid  = 1'b0;
    inLeft   = 32'd0;
    inRight  = 32'd0;
    inOpcode = 2'd0;
    outReady = 1'b1;

    stepCycle();
    stepCycle();
    checkOutput("resetOutValid", 32'(outValid), 32'd0);
    checkOutput("resetOutResult", outResult, 32'd0);
    checkOutput("resetOutCarry", 32'(outCarry), 32'd0);
    checkOutput("resetOutZero", 32'(outZero), 32'd0);
    checkOutput("resetAluLeft", 32'(aluLeft), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("postResetInReady", 32'(inReady), 32'd1);

    $display("[TB] ADD 0x000000FF + 0x00000001");
    applyStimulus(OP_ADD, 32'h0000_00FF, 32'h0000_0001);
    checkRun(OP_ADD, 32'h0000_00FF, 32'h0000_0001);
    checkResult("add1", 32'h0000_0100, 1'b0, 1'b0);
    consume("add1", 32'h0000_0100);

    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    checkRun(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    checkResult("addWrap", 32'h0000_0000, 1'b1, 1'b1);
    consume("addWrap", 32'h0000_0000);

    applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    checkRun(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    checkResult("addSign", 32'h8000_0000, 1'b0, 1'b0);
    consume("addSign", 32'h8000_0000);

    applyStimulus(OP_SUB, 32'h0000_0100, 32'h0000_0001);
    checkRun(OP_SUB, 32'h0000_0100, 32'h0000_0001);
    checkResult("sub1", 32'h0000_00FF, 1'b0, 1'b0);
    consume("sub1", 32'h0000_00FF);

    applyStimulus(OP_SUB, 32'h0000_0000, 32'h0000_0001);
    checkRun(OP_SUB, 32'h0000_0000, 32'h0000_0001);
    checkResult("subBorrow", 32'hFFFF_FFFF, 1'b1, 1'b0);
    consume("subBorrow", 32'hFFFF_FFFF);

    applyStimulus(OP_AND, 32'hAAAA_5555, 32'h5555_5555);
    checkRun(OP_AND, 32'hAAAA_5555, 32'h5555_5555);
    checkResult("and", 32'h0000_5555, 1'b0, 1'b0);
    consume("and", 32'h0000_5555);

    applyStimulus(OP_OR, 32'hAAAA_5555, 32'h5555_5555);
    checkRun(OP_OR, 32'hAAAA_5555, 32'h5555_5555);
    checkResult("or", 32'hFFFF_5555, 1'b0, 1'b0);
    consume("or", 32'hFFFF_5555);

    $display("[TB] backpressure with a pending request");
    outReady = 1'b0;
    applyStimulus(OP_ADD, 32'h0000_00FF, 32'h0000_0001);
    checkRun(OP_ADD, 32'h0000_00FF, 32'h0000_0001);
    inValid  = 1'b1;
    inLeft   = 32'h1234_5678;
    inRight  = 32'h1111_1111;
    inOpcode = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      checkResult($sformatf("stall%0d", i), 32'h0000_0100, 1'b0, 1'b0);
      checkOutput($sformatf("stallInReady%0d", i), 32'(inReady), 32'd0);
      stepCycle();
    end
    checkResult("stallEnd", 32'h0000_0100, 1'b0, 1'b0);
    outReady = 1'b1;
    stepCycle();
    checkOutput("bpIdleInReady", 32'(inReady), 32'd1);
    checkOutput("bpIdleOutValid", 32'(outValid), 32'd0);
    checkOutput("bpIdleHold", outResult, 32'h0000_0100);
    stepCycle();
    inValid = 1'b0;
    checkRun(OP_ADD, 32'h1234_5678, 32'h1111_1111);
    checkResult("pending", 32'h2345_6789, 1'b0, 1'b0);
    consume("pending", 32'h2345_6789);

    $display("[TB] reset during RUN");
    applyStimulus(OP_ADD, 32'h0101_0101, 32'h0202_0202);
    stepCycle();
    stepCycle();
    checkOutput("midRunAluLeft", 32'(aluLeft), 32'h01);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("abortOutValid", 32'(outValid), 32'd0);
    checkOutput("abortInReady", 32'(inReady), 32'd1);
    checkOutput("abortOutResult", outResult, 32'd0);
    checkOutput("abortOutCarry", 32'(outCarry), 32'd0);
    checkOutput("abortOutZero", 32'(outZero), 32'd0);
    checkOutput("abortAluLeft", 32'(aluLeft), 32'd0);
    validSeen = 0;
    for (int i = 0; i < 8; i++) begin
      if (outValid) validSeen++;
      stepCycle();
    end
    checkOutput("abortNoResult", 32'(validSeen), 32'd0);

    applyStimulus(OP_OR, 32'hF0F0_F0F0, 32'h0F0F_0F00);
    checkRun(OP_OR, 32'hF0F0_F0F0, 32'h0F0F_0F00);
    checkResult("afterAbort", 32'hFFFF_FFF0, 1'b0, 1'b0);
    consume("afterAbort", 32'hFFFF_FFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-cycle sequencer that drives the shared 8-bit `alu8` datapath to perform word-wide ADD, SUB, AND and OR. It accepts a word operation on a valid/ready input channel. It feeds the ALU one byte per cycle, least-significant byte first, and chains the ALU carry/borrow between bytes. It then presents the assembled word on a valid/ready output channel. `alu8` is instantiated beside this block by the parent; the sequencer is the initiator on the ALU's `left`/`right`/`opcode`/`status_in` → `result`/`status_out` interface.

## Interface
Parameters:
- `BYTES`, default 4: operand width in bytes; `W = 8*BYTES`; legal range 2..16.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at a rising edge.
- `in_left`  in  W  left operand.
- `in_right`  in  W  right operand.
- `in_opcode`  in  2  0=ADD, 1=SUB, 2=AND, 3=OR.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  W  word result.
- `out_carry`  out  1  final carry (ADD) / borrow (SUB); 0 for AND/OR.
- `out_zero`  out  1  `out_result == 0`.
- `alu_left`  out  8  byte to `alu8.left`.
- `alu_right`  out  8  byte to `alu8.right`.
- `alu_opcode`  out  2  to `alu8.opcode`.
- `alu_status_in`  out  1  to `alu8.status_in`.
- `alu_result`  in  8  from `alu8.result`.
- `alu_status_out`  in  1  from `alu8.status_out`.

## Operation
- ALU contract:
  - ADD: `result = left + right + status_in`; `status_out` = carry.
  - SUB: `result = left - right - status_in`; `status_out` = borrow.
  - AND/OR: `status_out` is don't-care.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On accept, latch operands and opcode, clear byte index `idx`, clear carry register, go to RUN.
- RUN:
  - `alu_left`/`alu_right` = byte `idx` of the latched operands.
  - `alu_opcode` = latched opcode.
  - `alu_status_in` = 0 when `idx`=0, otherwise the carry register; forced 0 for AND/OR.
  - Each edge: write `alu_result` into result byte `idx`; carry register <= `alu_status_out` (ADD/SUB) or 0 (AND/OR); increment `idx`.
  - At the edge where `idx == BYTES-1`, go to DONE.
- DONE:
  - `out_valid`=1; `out_carry` = carry register; `out_zero` = result == 0 (registered).
  - Return to IDLE on the edge where `out_ready`=1.
- `in_ready`=0 in RUN and DONE; `in_*` are ignored outside IDLE.
- `out_result`/`out_carry`/`out_zero` hold stable from the first DONE cycle until accepted, and keep their values in IDLE until the next operation overwrites them.
- In IDLE and DONE, the `alu_*` outputs drive 0.
- Arithmetic is modulo 2^W; no overflow flag.

## Timing
- Reset (edge with `reset`=1) forces: state IDLE, `idx` 0, carry 0, `out_valid` 0, `out_result` 0, `out_carry` 0, `out_zero` 0, latched operands 0.
- `in_ready` reads 1 from the cycle after reset deasserts.
- Reset overrides everything. A reset asserted in RUN or DONE aborts the operation; no result is emitted and the next cycle is IDLE.
- Latency: accept at edge E0. RUN occupies cycles E0..E0+BYTES, capturing bytes at edges E0+1..E0+BYTES. `out_valid` is 1 starting in the cycle after edge E0+BYTES.
- Throughput: at most one operation per BYTES+2 cycles. `out_ready` tied high gives a steady-state rate of exactly BYTES+2.
- A DONE→IDLE edge and a new accept cannot coincide: `in_ready` is 0 in DONE.
- The ALU path is combinational. The `alu_result` byte for index `idx` must settle within the same cycle it is driven.

## Test plan
Bench instantiates `alu8` (or an equivalent model) with `BYTES`=4.
- ADD `0x000000FF` + `0x00000001` -> `0x00000100`, `out_carry`=0, `out_zero`=0. `out_valid` asserts 4 cycles after the accept edge. `alu_status_in` reads 0,1,0,0 across the four RUN cycles.
- ADD `0xFFFFFFFF` + `0x00000001` -> `0x00000000`, `out_carry`=1, `out_zero`=1. ADD `0x7FFFFFFF` + `0x00000001` -> `0x80000000`, carry 0.
- SUB `0x00000100` - `0x00000001` -> `0x000000FF`, `out_carry`=0. SUB `0x00000000` - `0x00000001` -> `0xFFFFFFFF`, `out_carry`=1.
- AND `0xAAAA5555`, `0x55555555` -> `0x00005555`. OR on the same operands -> `0xFFFF5555`. `out_carry`=0 and `alu_status_in`=0 on every byte.
- Backpressure: hold `out_ready`=0 for 3 cycles after `out_valid` -> output stays stable and `in_ready`=0. A request with `in_valid`=1 and operands `0x12345678` is ignored until IDLE. That request is then accepted and its result is produced.
- Reset mid-RUN (`reset`=1 at `idx`=2) -> next cycle `out_valid`=0, `in_ready`=1, outputs 0. The aborted operation never emits a result.
